player_state_rx: RTL and testbench

PLAYER_STATE_RX -- requirements
Module: player_state_rx

---
 rtl/player_state_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_player_state_rx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_state_rx.sv
// player_state_rx: receives remote player state frames from the inter-board serial line.
//
// Frame format: a start bit (0), then 24 data bits sent MSB first, then an even-parity
// bit, then a stop bit (1). The 24 data bits are laid out as:
//   [23:22] sender ID, [21:20] direction, [19:11] x, [10:2] y, [1] chop (ignored), [0] carry.
// A good frame from a remote player updates that player's slot. Slot a/b/c is the sender
// ID with this board's own ID skipped.
//
// Ports:
//   clk               system clock (rising edge)
//   reset_n           asynchronous active-low reset
//   serial_in         serial line, idles high, asynchronous to clk
//   game_state[2:0]   global game state (0 = WELCOME)
//   num_players[1:0]  player count minus one
//   local_player_ID   this board's player ID
//   player_{a,b,c}_x/_y/_dir/_carry   remote player state (registered)
//   frame_valid       one-cycle pulse when an accepted frame is applied
//   frame_error       one-cycle pulse on a parity or stop-bit error
module player_state_rx #(
    parameter int unsigned CYCLES_PER_BIT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    input  logic [2:0] game_state,
    input  logic [1:0] num_players,
    input  logic [1:0] local_player_ID,
    output logic [8:0] player_a_x,
    output logic [8:0] player_b_x,
    output logic [8:0] player_c_x,
    output logic [8:0] player_a_y,
    output logic [8:0] player_b_y,
    output logic [8:0] player_c_y,
    output logic [1:0] player_a_dir,
    output logic [1:0] player_b_dir,
    output logic [1:0] player_c_dir,
    output logic       player_a_carry,
    output logic       player_b_carry,
    output logic       player_c_carry,
    output logic       frame_valid,
    output logic       frame_error
);

    localparam int unsigned CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_t;

    // Reset release is synchronized. The third stage keeps the FSM idle until the line
    // synchronizer and the edge-detect flop both hold real line values, so a line that
    // is already low when reset is released is not mistaken for a falling edge.
    logic [2:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 3'b000;
        end else begin
            rst_sync_q <= {rst_sync_q[1:0], 1'b1};
        end
    end

    assign run = rst_sync_q[2];

    // Two-flop line synchronizer plus the previous value for falling-edge detection.
    logic [1:0] rx_sync_q;
    logic       rx_prev_q;
    logic       rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], serial_in};
            rx_prev_q <= rx_sync_q[1];
        end
    end

    assign rx = rx_sync_q[1];

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    bit_cnt_q;
    logic [23:0]   shreg_q;
    logic          par_bit_q;
    logic          apply_q;
    logic          err_q;
    logic [1:0]    slot_q;

    // Decode of the completed data word. Only used while in StStop.
    logic [1:0] rx_id;
    logic       parity_ok;
    logic       discard;
    logic [1:0] slot;

    assign rx_id     = shreg_q[23:22];
    assign parity_ok = (^shreg_q) == par_bit_q;
    assign discard   = (rx_id == local_player_ID) || (rx_id > num_players);
    assign slot      = (rx_id < local_player_ID) ? rx_id : rx_id - 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            apply_q   <= 1'b0;
            err_q     <= 1'b0;
            slot_q    <= 2'd0;
        end else begin
            apply_q <= 1'b0;
            err_q   <= 1'b0;
            if (run) begin
                case (state_q)
                    StIdle: begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        if (rx_prev_q && !rx) begin
                            state_q <= StStart;
                        end
                    end
                    StStart: begin
                        if (cnt_q == HALF_LAST) begin
                            cnt_q   <= '0;
                            // A start bit that is already high again was a glitch.
                            state_q <= rx ? StIdle : StData;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q     <= '0;
                            shreg_q   <= {shreg_q[22:0], rx};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 5'd23) begin
                                state_q <= StParity;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StParity: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q     <= '0;
                            par_bit_q <= rx;
                            state_q   <= StStop;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q <= '0;
                            if (!parity_ok || !rx) begin
                                err_q <= 1'b1;
                            end else if (!discard) begin
                                apply_q <= 1'b1;
                                slot_q  <= slot;
                            end
                            state_q <= rx ? StIdle : StWaitIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWaitIdle: begin
                        // Need a full bit period of continuous high before re-arming.
                        if (!rx) begin
                            cnt_q <= '0;
                        end else if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Slot registers. The whole slot loads in one edge from the held shift register,
    // so a partially received frame never reaches the outputs.
    logic [8:0] x_q     [3];
    logic [8:0] y_q     [3];
    logic [1:0] dir_q   [3];
    logic       carry_q [3];
    logic       welcome;

    assign welcome = (game_state == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                x_q[k]     <= 9'd0;
                y_q[k]     <= 9'd0;
                dir_q[k]   <= 2'd3;
                carry_q[k] <= 1'b0;
            end
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= apply_q && !welcome;
            frame_error <= err_q;
            for (int k = 0; k < 3; k++) begin
                if (welcome || (2'(k) >= num_players)) begin
                    x_q[k]     <= 9'd0;
                    y_q[k]     <= 9'd0;
                    dir_q[k]   <= 2'd3;
                    carry_q[k] <= 1'b0;
                end else if (apply_q && (slot_q == 2'(k))) begin
                    x_q[k]     <= shreg_q[19:11];
                    y_q[k]     <= shreg_q[10:2];
                    dir_q[k]   <= shreg_q[21:20];
                    carry_q[k] <= shreg_q[0];
                end
            end
        end
    end

    assign player_a_x     = x_q[0];
    assign player_b_x     = x_q[1];
    assign player_c_x     = x_q[2];
    assign player_a_y     = y_q[0];
    assign player_b_y     = y_q[1];
    assign player_c_y     = y_q[2];
    assign player_a_dir   = dir_q[0];
    assign player_b_dir   = dir_q[1];
    assign player_c_dir   = dir_q[2];
    assign player_a_carry = carry_q[0];
    assign player_b_carry = carry_q[1];
    assign player_c_carry = carry_q[2];

endmodule

// File: tb/tb_player_state_rx.sv
// Testbench for player_state_rx: directed frames for each scenario plus randomized
// frames, checked against a slot-level reference model through a scoreboard queue.
module tb_player_state_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b1;
    logic [2:0] game_state = 3'd2;
    logic [1:0] num_players = 2'd3;
    logic [1:0] local_player_ID = 2'd1;
    logic [8:0] player_a_x, player_b_x, player_c_x;
    logic [8:0] player_a_y, player_b_y, player_c_y;
    logic [1:0] player_a_dir, player_b_dir, player_c_dir;
    logic       player_a_carry, player_b_carry, player_c_carry;
    logic       frame_valid, frame_error;

    player_state_rx #(.CYCLES_PER_BIT(CPB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .serial_in      (serial_in),
        .game_state     (game_state),
        .num_players    (num_players),
        .local_player_ID(local_player_ID),
        .player_a_x     (player_a_x),
        .player_b_x     (player_b_x),
        .player_c_x     (player_c_x),
        .player_a_y     (player_a_y),
        .player_b_y     (player_b_y),
        .player_c_y     (player_c_y),
        .player_a_dir   (player_a_dir),
        .player_b_dir   (player_b_dir),
        .player_c_dir   (player_c_dir),
        .player_a_carry (player_a_carry),
        .player_b_carry (player_b_carry),
        .player_c_carry (player_c_carry),
        .frame_valid    (frame_valid),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            err;
        logic [2:0][8:0] x;
        logic [2:0][8:0] y;
        logic [2:0][1:0] d;
        logic [2:0]      c;
    } snap_t;

    snap_t sb[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: what each slot should currently show.
    logic [8:0] mx   [3];
    logic [8:0] my   [3];
    logic [1:0] mdir [3];
    logic       mcar [3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = 9'd0; my[k] = 9'd0; mdir[k] = 2'd3; mcar[k] = 1'b0;
        end
    endfunction

    // Lobby screen or a slot beyond the player count shows the default pose.
    function automatic void model_normalize();
        for (int k = 0; k < 3; k++) begin
            if (game_state == 3'd0 || k >= int'(num_players)) begin
                mx[k] = 9'd0; my[k] = 9'd0; mdir[k] = 2'd3; mcar[k] = 1'b0;
            end
        end
    endfunction

    function automatic snap_t model_snap(input logic err);
        snap_t s;
        s.err = err;
        for (int k = 0; k < 3; k++) begin
            s.x[k] = mx[k]; s.y[k] = my[k]; s.d[k] = mdir[k]; s.c[k] = mcar[k];
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.err  = frame_error;
        s.x    = {player_c_x, player_b_x, player_a_x};
        s.y    = {player_c_y, player_b_y, player_a_y};
        s.d    = {player_c_dir, player_b_dir, player_a_dir};
        s.c    = {player_c_carry, player_b_carry, player_a_carry};
        return s;
    endfunction

    // Predict the response to one frame and queue it if a pulse is expected.
    function automatic void model_frame(input logic [23:0] d, input bit bad);
        int id;
        int lid;
        int slot;
        id  = int'(d[23:22]);
        lid = int'(local_player_ID);
        model_normalize();
        if (bad) begin
            sb.push_back(model_snap(1'b1));
            return;
        end
        if (game_state == 3'd0) return;
        if (id == lid || id > int'(num_players)) return;
        slot = (id < lid) ? id : id - 1;
        mx[slot] = d[19:11]; my[slot] = d[10:2]; mdir[slot] = d[21:20]; mcar[slot] = d[0];
        model_normalize();
        sb.push_back(model_snap(1'b0));
    endfunction

    function automatic logic [23:0] mk(input int id, input int dir, input int x, input int y,
                                       input int carry);
        logic [23:0] d;
        d = {2'(id), 2'(dir), 9'(x), 9'(y), 1'($urandom_range(1)), 1'(carry)};
        return d;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        snap_t a;
        snap_t e;
        a = dut_snap();
        a.err = 1'b0;
        e = model_snap(1'b0);
        tests++;
        if (a !== e || frame_valid !== 1'b0 || frame_error !== 1'b0) begin
            fails++;
            $display("FAIL %s: got %h fv=%b fe=%b, expected %h with no pulse", name, a,
                     frame_valid, frame_error, e);
        end
    endtask

    // Monitor: each pulse must match the oldest queued prediction.
    always @(negedge clk) begin
        if (reset_n && (frame_valid || frame_error)) begin
            snap_t a;
            snap_t e;
            tests++;
            if (frame_valid && frame_error) begin
                fails++;
                $display("FAIL pulse_excl: frame_valid=1 frame_error=1, expected one at most");
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: fv=%b fe=%b, expected no pulse",
                         frame_valid, frame_error);
            end else begin
                e = sb.pop_front();
                a = dut_snap();
                if (a !== e) begin
                    fails++;
                    $display("FAIL frame_result: got %h, expected %h", a, e);
                end
            end
        end
    end

    // Drive one frame. abort_at >= 0 pulses reset just before that data bit index.
    task automatic send_frame(input logic [23:0] d, input bit flip_par, input bit stop_v,
                              input int abort_at, input string name);
        serial_in = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 24; i++) begin
            if (abort_at == i) begin
                reset_n = 1'b0;
                #2;
                serial_in = 1'b1;
                model_reset();
                sb.delete();
                wait_cyc(3);
                reset_n = 1'b1;
                wait_cyc(4 * CPB);
                return;
            end
            serial_in = d[23-i];
            wait_cyc(CPB);
        end
        serial_in = (^d) ^ flip_par;
        wait_cyc(CPB);
        serial_in = stop_v;
        wait_cyc(CPB);
        serial_in = 1'b1;
        wait_cyc(3 * CPB);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d pulses missing, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic frame(input logic [23:0] d, input bit flip_par, input bit stop_v,
                         input string name);
        model_frame(d, flip_par || !stop_v);
        send_frame(d, flip_par, stop_v, -1, name);
        check_outputs(name);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] d;
        model_reset();
        #23;
        check_outputs("reset_state");
        reset_n = 1'b1;
        wait_cyc(6);
        check_outputs("after_release");

        // Four players, this board is ID 1, in play.
        frame(mk(2, 1, 208, 176, 1), 1'b0, 1'b1, "id2_to_b");
        frame(mk(1, 0, 400, 100, 0), 1'b0, 1'b1, "own_id");
        frame(mk(0, 2, 400, 272, 0), 1'b0, 1'b1, "id0_to_a");
        frame(mk(3, 0, 17, 33, 1), 1'b0, 1'b1, "id3_to_c");
        frame(mk(2, 3, 5, 6, 0), 1'b1, 1'b1, "parity_err");
        frame(mk(2, 3, 5, 6, 0), 1'b0, 1'b0, "stop_err");
        frame(mk(2, 2, 300, 200, 0), 1'b0, 1'b1, "after_stop_err");
        frame(mk(0, 1, 9, 9, 1), 1'b1, 1'b0, "both_err");

        // One-cycle low glitch while idle.
        serial_in = 1'b0;
        wait_cyc(1);
        serial_in = 1'b1;
        wait_cyc(3 * CPB);
        check_outputs("glitch");

        // Reset in the middle of a frame, then a full frame.
        send_frame(mk(0, 0, 77, 88, 1), 1'b0, 1'b1, 10, "abort");
        check_outputs("mid_frame_reset");
        frame(mk(3, 1, 123, 45, 1), 1'b0, 1'b1, "after_reset");

        // Two players, this board is ID 0.
        num_players = 2'd1;
        local_player_ID = 2'd0;
        wait_cyc(2);
        frame(mk(2, 1, 50, 60, 1), 1'b0, 1'b1, "id_gt_players");
        frame(mk(1, 1, 50, 60, 1), 1'b0, 1'b1, "np1_id1");
        game_state = 3'd0;
        wait_cyc(2);
        frame(mk(1, 2, 111, 222, 1), 1'b0, 1'b1, "welcome_hold");
        frame(mk(1, 2, 111, 222, 1), 1'b1, 1'b1, "welcome_err");

        // Randomized configurations and frames.
        for (int n = 0; n < 40; n++) begin
            int r;
            if (n % 5 == 0) begin
                game_state = ($urandom_range(9) == 0) ? 3'd0 : 3'($urandom_range(4, 1));
                num_players = 2'($urandom_range(3));
                local_player_ID = 2'($urandom_range(int'(num_players)));
                wait_cyc(2);
            end
            d = mk($urandom_range(3), $urandom_range(3), $urandom_range(511),
                   $urandom_range(511), $urandom_range(1));
            r = $urandom_range(9);
            frame(d, r == 0, r != 1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
